traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

- Passive checker on the `lightWE`/`lightNS` outputs of the intersection traffic-light controller.
- Samples both light buses every clock and tracks the expected phase sequence.
- Checks encoding, conflict, sequence and dwell time, and reports sticky error flags, the current phase and a count of completed cycles.
- Sits beside the controller on the same clock and drives nothing back into it.

## Interface
Parameters:
- `GREEN_CYCLES`, 14: required dwell of each green phase, in clocks.
- `YELLOW_CYCLES`, 3: required dwell of each yellow phase.
- `ALLRED_CYCLES`, 3: required dwell of each all-red phase.

Ports:
- `clk`  in  1  single clock; all sampling and state on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `lightWE`  in  3  WE light, one-hot: 001 green, 010 yellow, 100 red.
- `lightNS`  in  3  NS light, same encoding.
- `clr_err`  in  1  synchronous clear of all sticky error flags.
- `locked`  out  1  high once the monitor has seen a legal phase transition.
- `phase`  out  3  tracked phase: 0 SYNC, 1 WE_G, 2 WE_Y, 3 AR1, 4 NS_G, 5 NS_Y, 6 AR2.
- `err_encoding`  out  1  sticky: a bus was not one-hot.
- `err_conflict`  out  1  sticky: neither bus was red.
- `err_sequence`  out  1  sticky: an illegal phase transition was seen.
- `err_timing`  out  1  sticky: a phase dwell was not equal to its parameter.
- `err_pulse`  out  1  one-clock pulse on any newly detected error.
- `cycles_done`  out  16  count of complete legal cycles; saturates at 0xFFFF.

## Operation
- Pattern decode, with WE listed first:
  - G/R = WE_G
  - Y/R = WE_Y
  - R/R = all-red (AR1 or AR2, depending on the predecessor)
  - R/G = NS_G
  - R/Y = NS_Y
- Legal order: WE_G→WE_Y→AR1→NS_G→NS_Y→AR2→WE_G.
- A sample equal to the current phase is a stay. R/R in AR1 or AR2 is a stay.
- Encoding error: either bus not in {001,010,100}. This also sets `err_conflict` if neither bus is 100. Phase goes to SYNC; `locked` clears.
- Conflict error: both buses one-hot, neither red. Phase goes to SYNC; `locked` clears.
- SYNC behaviour:
  - The first legal pattern enters the matching phase, marked partial.
  - R/R from SYNC maps to AR2.
  - No dwell check is made for a partial phase.
- Sequence error: a legal pattern that is neither a stay nor the legal successor.
  - Sets `err_sequence`.
  - Resyncs to the decoded phase, marked partial; `locked` clears.
- `locked` sets on the first legal transition out of any phase.
- `cycles_done` increments on each legal AR2→WE_G transition while `locked` is high.
- Dwell counter, 8 bits, saturating:
  - Loads 1 on phase entry and increments on each stay.
  - Overstay: when the dwell reaches parameter+1, set `err_timing` once for that phase.
  - Understay: on a legal exit with dwell < parameter and the phase not partial, set `err_timing`.
- Simultaneous events:
  - A new error in the same cycle as `clr_err` wins: the flag stays set.
  - Several errors in one sample set all matching flags; `err_pulse` is a single pulse.
- `err_pulse` fires only on a detection event, not while a flag merely stays set.

## Timing
- All outputs are registered. A sample taken at edge N is reflected in the outputs after edge N.
- Reset values:
  - `phase` = 0 (SYNC)
  - `locked` = 0
  - all `err_*` = 0
  - `err_pulse` = 0
  - `cycles_done` = 0
  - dwell counter = 0
- Reset asserted mid-cycle clears everything immediately, independent of `clk`.
- The first sample after deassertion is treated as coming from SYNC.
- For a controller held in reset together with the monitor:
  - first post-reset sample G/R enters WE_G (partial);
  - `locked` goes high at the WE_G→WE_Y edge, 14 clocks later.
- Error detection latency is one clock. Overstay is flagged on the edge that samples dwell = parameter+1.
- `clr_err` takes effect on the next edge.

## Configuration
- `TLM_TIMING_CHECK_EN` defined: the dwell counter, overstay check and understay check are built; `err_timing` behaves as specified.
- `TLM_TIMING_CHECK_EN` undefined: no dwell counter; `err_timing` is tied to 0; all other behaviour is unchanged.

## Test plan
- Reset release, then a conforming controller stream of 3 full cycles (14/3/3/14/3/3):
  - `locked` = 1 after 14 clocks;
  - `cycles_done` = 3 after the third AR2→WE_G;
  - all `err_*` = 0.
- Force `lightWE` = 001 and `lightNS` = 001 for one clock during NS_G: `err_conflict` = 1, `err_pulse` for one clock, `phase` = 0, `locked` = 0.
- Inject `lightWE` = 011: `err_encoding` = 1; monitor relocks on the next legal transition.
- Skip NS_Y, going NS_G→R/R: `err_sequence` = 1; `phase` = 6 (AR2, partial); no `err_timing` on that AR2 exit.
- WE_G held 15 clocks: `err_timing` sets on the 15th sample. Separately, WE_Y held 2 clocks: `err_timing` sets at the exit edge. Without `TLM_TIMING_CHECK_EN`, `err_timing` stays 0 in both cases.
- `clr_err` pulsed in the same clock as a new conflict: `err_conflict` stays 1. Pulsed alone: all flags go to 0 next clock. `rst_n` low mid-NS_G: all outputs are 0 immediately.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Passive checker that watches the WE/NS light buses of an intersection
// traffic-light controller. It tracks the phase sequence
// WE_G -> WE_Y -> AR1 -> NS_G -> NS_Y -> AR2 -> WE_G, and flags bad light
// encodings, conflicting greens, illegal transitions and wrong phase dwell
// times. It never drives anything back into the controller.
//
// Optional feature macro: TLM_TIMING_CHECK_EN
//   defined   : dwell counter plus overstay/understay checks drive err_timing
//   undefined : no dwell counter, err_timing is tied to 0
//
// Ports:
//   clk          in   rising-edge clock, all sampling and state
//   rst_n        in   asynchronous active-low reset
//   lightWE      in   [2:0] WE light, one-hot 001 green / 010 yellow / 100 red
//   lightNS      in   [2:0] NS light, same encoding
//   clr_err      in   synchronous clear of the sticky error flags
//   locked       out  high after a legal phase transition has been seen
//   phase        out  [2:0] 0 SYNC,1 WE_G,2 WE_Y,3 AR1,4 NS_G,5 NS_Y,6 AR2
//   err_encoding out  sticky: a bus was not one-hot
//   err_conflict out  sticky: neither bus was red
//   err_sequence out  sticky: illegal phase transition
//   err_timing   out  sticky: phase dwell differed from its parameter
//   err_pulse    out  one-clock pulse on any newly detected error
//   cycles_done  out  [15:0] completed legal cycles, saturating
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
  parameter int GREEN_CYCLES  = 14,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  lightWE,
  input  logic [2:0]  lightNS,
  input  logic        clr_err,
  output logic        locked,
  output logic [2:0]  phase,
  output logic        err_encoding,
  output logic        err_conflict,
  output logic        err_sequence,
  output logic        err_timing,
  output logic        err_pulse,
  output logic [15:0] cycles_done
);

  // The 8-bit saturating dwell counter must be able to reach limit+1.
  if (GREEN_CYCLES < 1 || GREEN_CYCLES > 254 ||
      YELLOW_CYCLES < 1 || YELLOW_CYCLES > 254 ||
      ALLRED_CYCLES < 1 || ALLRED_CYCLES > 254) begin : g_bad_param
    $error("traffic_light_monitor: dwell parameters must be in 1..254");
  end

  typedef enum logic [2:0] {
    PH_SYNC = 3'd0,
    PH_WE_G = 3'd1,
    PH_WE_Y = 3'd2,
    PH_AR1  = 3'd3,
    PH_NS_G = 3'd4,
    PH_NS_Y = 3'd5,
    PH_AR2  = 3'd6
  } phase_t;

  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] RED = 3'b100;

  phase_t      phase_reg, phase_next;
  phase_t      dec_phase, succ_phase;
  logic        partial_reg, partial_next;
  logic        locked_reg, locked_next;
  logic [2:0]  err_reg, err_next;        // {encoding, conflict, sequence}
  logic        pulse_reg, pulse_next;
  logic [15:0] cycles_reg, cycles_next;

  logic we_ok, ns_ok;
  logic ev_encoding, ev_conflict, ev_sequence, ev_timing;
  logic legal, is_stay, is_succ;

  // ---------------------------------------------------------------------------
  // Sample classification
  // ---------------------------------------------------------------------------
  always_comb begin
    we_ok       = (lightWE == GRN) || (lightWE == YEL) || (lightWE == RED);
    ns_ok       = (lightNS == GRN) || (lightNS == YEL) || (lightNS == RED);
    ev_encoding = !we_ok || !ns_ok;
    // Also covers the malformed case: a bad bus with no red anywhere.
    ev_conflict = (lightWE != RED) && (lightNS != RED);
    legal       = !ev_encoding && !ev_conflict;
  end

  // Decoded phase of a legal sample. All-red is ambiguous: it is a stay in
  // either all-red phase, AR1 after a WE phase, AR2 otherwise (incl. SYNC).
  always_comb begin
    if (lightWE == GRN)                                    dec_phase = PH_WE_G;
    else if (lightWE == YEL)                               dec_phase = PH_WE_Y;
    else if (lightNS == GRN)                               dec_phase = PH_NS_G;
    else if (lightNS == YEL)                               dec_phase = PH_NS_Y;
    else if (phase_reg == PH_AR1 || phase_reg == PH_AR2)   dec_phase = phase_reg;
    else if (phase_reg == PH_WE_G || phase_reg == PH_WE_Y) dec_phase = PH_AR1;
    else                                                   dec_phase = PH_AR2;
  end

  always_comb begin
    case (phase_reg)
      PH_WE_G: succ_phase = PH_WE_Y;
      PH_WE_Y: succ_phase = PH_AR1;
      PH_AR1:  succ_phase = PH_NS_G;
      PH_NS_G: succ_phase = PH_NS_Y;
      PH_NS_Y: succ_phase = PH_AR2;
      PH_AR2:  succ_phase = PH_WE_G;
      default: succ_phase = PH_SYNC;
    endcase
  end

  always_comb begin
    is_stay     = (phase_reg != PH_SYNC) && (dec_phase == phase_reg);
    is_succ     = (phase_reg != PH_SYNC) && (dec_phase == succ_phase);
    ev_sequence = legal && (phase_reg != PH_SYNC) && !is_stay && !is_succ;
  end

  // ---------------------------------------------------------------------------
  // Optional dwell checking
  // ---------------------------------------------------------------------------
`ifdef TLM_TIMING_CHECK_EN
  logic [7:0] dwell_reg, dwell_next, dwell_inc;
  logic [8:0] dwell_limit;
  logic       timing_reg;

  always_comb begin
    case (phase_reg)
      PH_WE_G, PH_NS_G: dwell_limit = 9'(GREEN_CYCLES);
      PH_WE_Y, PH_NS_Y: dwell_limit = 9'(YELLOW_CYCLES);
      PH_AR1, PH_AR2:   dwell_limit = 9'(ALLRED_CYCLES);
      default:          dwell_limit = 9'd0;
    endcase
  end

  always_comb begin
    dwell_inc = (dwell_reg == 8'hFF) ? 8'hFF : dwell_reg + 8'd1;
    if (!legal)       dwell_next = 8'd0;
    else if (is_stay) dwell_next = dwell_inc;
    else              dwell_next = 8'd1;
    // Dwell grows monotonically inside a phase, so the equality below can
    // only fire once per phase. Partially observed phases are never judged.
    ev_timing = legal && !partial_reg &&
                ((is_stay && ({1'b0, dwell_inc} == dwell_limit + 9'd1)) ||
                 (is_succ && ({1'b0, dwell_reg} <  dwell_limit)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_reg  <= 8'd0;
      timing_reg <= 1'b0;
    end else begin
      dwell_reg  <= dwell_next;
      timing_reg <= (timing_reg && !clr_err) || ev_timing;
    end
  end

  assign err_timing = timing_reg;
`else
  assign ev_timing  = 1'b0;
  assign err_timing = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg   <= PH_SYNC;
      partial_reg <= 1'b0;
      locked_reg  <= 1'b0;
      err_reg     <= 3'b000;
      pulse_reg   <= 1'b0;
      cycles_reg  <= 16'd0;
    end else begin
      phase_reg   <= phase_next;
      partial_reg <= partial_next;
      locked_reg  <= locked_next;
      err_reg     <= err_next;
      pulse_reg   <= pulse_next;
      cycles_reg  <= cycles_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_next   = phase_reg;
    partial_next = partial_reg;
    locked_next  = locked_reg;
    if (!legal) begin
      phase_next   = PH_SYNC;
      partial_next = 1'b0;
      locked_next  = 1'b0;
    end else if (phase_reg == PH_SYNC) begin
      phase_next   = dec_phase;
      partial_next = 1'b1;
    end else if (is_succ) begin
      phase_next   = dec_phase;
      partial_next = 1'b0;
      locked_next  = 1'b1;
    end else if (!is_stay) begin
      // Illegal jump: follow the lights but distrust the new phase's start.
      phase_next   = dec_phase;
      partial_next = 1'b1;
      locked_next  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (flags, pulse, cycle count), registered above
  // ---------------------------------------------------------------------------
  always_comb begin
    // A detection in the same sample as clr_err wins over the clear.
    err_next    = (err_reg & {3{~clr_err}}) | {ev_encoding, ev_conflict, ev_sequence};
    pulse_next  = ev_encoding || ev_conflict || ev_sequence || ev_timing;
    cycles_next = cycles_reg;
    if (legal && is_succ && (phase_reg == PH_AR2) && locked_reg && (cycles_reg != 16'hFFFF))
      cycles_next = cycles_reg + 16'd1;
  end

  assign phase        = phase_reg;
  assign locked       = locked_reg;
  assign err_encoding = err_reg[2];
  assign err_conflict = err_reg[1];
  assign err_sequence = err_reg[0];
  assign err_pulse    = pulse_reg;
  assign cycles_done  = cycles_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
//
// Scoreboard bench: the driver applies one light sample per clock, advances a
// behavioural model of the checker and queues the expected outputs; the
// monitor pops one expectation per clock edge and compares every output.
// Directed scenarios are followed by a randomized controller stream with
// occasional dwell errors, skipped phases, garbage patterns and clears.
// -----------------------------------------------------------------------------
module tb_traffic_light_monitor;

  localparam int G = 14;
  localparam int Y = 3;
  localparam int A = 3;
`ifdef TLM_TIMING_CHECK_EN
  localparam bit TIMING_EN = 1'b1;
`else
  localparam bit TIMING_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  light_we = 3'b100;
  logic [2:0]  light_ns = 3'b100;
  logic        clr_err = 1'b0;
  logic        locked;
  logic [2:0]  phase;
  logic        err_encoding, err_conflict, err_sequence, err_timing, err_pulse;
  logic [15:0] cycles_done;

  traffic_light_monitor #(
    .GREEN_CYCLES (G),
    .YELLOW_CYCLES(Y),
    .ALLRED_CYCLES(A)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lightWE     (light_we),
    .lightNS     (light_ns),
    .clr_err     (clr_err),
    .locked      (locked),
    .phase       (phase),
    .err_encoding(err_encoding),
    .err_conflict(err_conflict),
    .err_sequence(err_sequence),
    .err_timing  (err_timing),
    .err_pulse   (err_pulse),
    .cycles_done (cycles_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int phase;
    bit locked;
    bit [3:0] flags;   // {encoding, conflict, sequence, timing}
    bit pulse;
    int cycles;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  // Behavioural model state
  int       m_phase = 0;
  int       m_dwell = 0;
  bit       m_partial = 0;
  bit       m_locked = 0;
  bit [3:0] m_flags = 0;
  bit       m_pulse = 0;
  int       m_cycles = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit onehot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic int limit_of(input int p);
    if (p == 1 || p == 4) return G;
    if (p == 2 || p == 5) return Y;
    return A;
  endfunction

  function automatic logic [2:0] pat_we(input int p);
    if (p == 1) return 3'b001;
    if (p == 2) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] pat_ns(input int p);
    if (p == 4) return 3'b001;
    if (p == 5) return 3'b010;
    return 3'b100;
  endfunction

  // Which phase a legal light pattern names, given where we believe we are.
  function automatic int classify(input logic [2:0] we, input logic [2:0] ns, input int cur);
    if (we == 3'b001) return 1;
    if (we == 3'b010) return 2;
    if (ns == 3'b001) return 4;
    if (ns == 3'b010) return 5;
    if (cur == 3 || cur == 6) return cur;
    if (cur == 1 || cur == 2) return 3;
    return 6;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_dwell = 0; m_partial = 0; m_locked = 0;
    m_flags = 0; m_pulse = 0; m_cycles = 0;
  endtask

  task automatic model_step(input logic [2:0] we, input logic [2:0] ns, input logic clr);
    bit [3:0] det;
    int dp;
    exp_t e;
    det = 4'b0000;
    det[3] = !onehot(we) || !onehot(ns);
    det[2] = (we != 3'b100) && (ns != 3'b100);
    if (det[3] || det[2]) begin
      m_phase = 0; m_locked = 0; m_partial = 0; m_dwell = 0;
    end else begin
      dp = classify(we, ns, m_phase);
      if (m_phase == 0) begin
        m_phase = dp; m_partial = 1; m_dwell = 1;
      end else if (dp == m_phase) begin
        if (m_dwell < 255) m_dwell++;
        if (!m_partial && m_dwell == limit_of(m_phase) + 1) det[0] = 1;
      end else if (dp == (m_phase % 6) + 1) begin
        if (!m_partial && m_dwell < limit_of(m_phase)) det[0] = 1;
        if (m_phase == 6 && m_locked && m_cycles < 65535) m_cycles++;
        m_phase = dp; m_partial = 0; m_locked = 1; m_dwell = 1;
      end else begin
        det[1] = 1;
        m_phase = dp; m_partial = 1; m_locked = 0; m_dwell = 1;
      end
    end
    if (!TIMING_EN) det[0] = 0;
    m_flags = (clr ? 4'b0000 : m_flags) | det;
    m_pulse = |det;
    e.phase = m_phase; e.locked = m_locked; e.flags = m_flags;
    e.pulse = m_pulse; e.cycles = m_cycles;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] we, input logic [2:0] ns, input logic clr);
    @(negedge clk);
    rst_n    = 1'b1;
    light_we = we;
    light_ns = ns;
    clr_err  = clr;
    model_step(we, ns, clr);
  endtask

  task automatic hold(input int p, input int n);
    for (int i = 0; i < n; i++) drive(pat_we(p), pat_ns(p), 1'b0);
  endtask

  task automatic full_cycle();
    for (int p = 1; p <= 6; p++) hold(p, limit_of(p));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_phase"}, int'(phase), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_errs"}, int'({err_encoding, err_conflict, err_sequence, err_timing}), 0);
    chk({tag, "_pulse"}, int'(err_pulse), 0);
    chk({tag, "_cycles"}, int'(cycles_done), 0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
  endtask

  // Monitor: one expectation per sampled edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      txn++;
      $display("txn %0d: phase=%0d locked=%0b err=%b pulse=%0b cycles=%0d", txn, phase, locked,
               {err_encoding, err_conflict, err_sequence, err_timing}, err_pulse, cycles_done);
      chk("phase", int'(phase), mon_e.phase);
      chk("locked", int'(locked), int'(mon_e.locked));
      chk("err_encoding", int'(err_encoding), int'(mon_e.flags[3]));
      chk("err_conflict", int'(err_conflict), int'(mon_e.flags[2]));
      chk("err_sequence", int'(err_sequence), int'(mon_e.flags[1]));
      chk("err_timing", int'(err_timing), int'(mon_e.flags[0]));
      chk("err_pulse", int'(err_pulse), int'(mon_e.pulse));
      chk("cycles_done", int'(cycles_done), mon_e.cycles);
    end
  end

  initial begin
    int p, n, r;
    logic [2:0] gw, gn;
    #2 check_all_zero("reset");

    // Conforming stream: three full cycles plus the closing WE_G sample.
    repeat (3) full_cycle();
    hold(1, G);

    // Conflicting greens for one clock during NS_G, then recover.
    hold(2, Y); hold(3, A); hold(4, 5);
    drive(3'b001, 3'b001, 1'b0);
    hold(4, 5); hold(5, Y); hold(6, A); hold(1, G);

    // Malformed WE bus, relock on the next legal transition.
    drive(3'b011, 3'b100, 1'b0);
    hold(2, Y); hold(3, A); hold(4, G);

    // Skip NS_Y: NS_G straight to all-red, short partial AR2 exit.
    hold(6, 1);

    // WE_G overstay (15 samples), then WE_Y understay (2 samples).
    hold(1, G + 1); hold(2, 2); hold(3, A); hold(4, G); hold(5, Y); hold(6, A);

    // Clear together with a new conflict, then a clear on its own.
    hold(1, 3);
    drive(3'b001, 3'b001, 1'b1);
    drive(3'b100, 3'b100, 1'b1);
    hold(6, A - 1); hold(1, G); hold(2, Y); hold(3, A); hold(4, 6);

    // Reset in the middle of NS_G.
    async_reset();

    // Randomized controller stream with occasional faults.
    p = 1;
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        gw = 3'($urandom_range(0, 7));
        gn = 3'($urandom_range(0, 7));
        drive(gw, gn, 1'($urandom_range(0, 3) == 0));
      end else begin
        if (r < 11) p = ((p + 1) % 6) + 1;
        n = limit_of(p);
        r = $urandom_range(0, 9);
        if (r == 0 && n > 1) n = n - 1;
        else if (r == 1) n = n + 1;
        for (int i = 0; i < n; i++)
          drive(pat_we(p), pat_ns(p), 1'($urandom_range(0, 29) == 0));
        p = (p % 6) + 1;
      end
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
